// File: rtl/h_gen_hour.sv
// Hour stage of the clock: synchronizes the minute stage's carry, keeps a BCD 00..23 hour,
// supports manual set, day rollover and hour alarm. Optional 12-hour display: H12_DISPLAY_EN.
module h_gen_hour #(
   parameter int SYNC_STAGES   = 2,
   parameter int RST_HOUR_HIGH = 0,
   parameter int RST_HOUR_LOW  = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       carry_in,
   input  logic       set_mode,
   input  logic       inc_btn,
   input  logic       dec_btn,
   input  logic [3:0] alarm_high,
   input  logic [3:0] alarm_low,
   output logic [3:0] hour_high,
   output logic [3:0] hour_low,
   output logic       day_pulse,
   output logic       alarm_hit
`ifdef H12_DISPLAY_EN
   ,
   output logic [3:0] disp_high,
   output logic [3:0] disp_low,
   output logic       pm
`endif
);

   localparam logic [7:0] RST_HOUR = {4'(RST_HOUR_HIGH), 4'(RST_HOUR_LOW)};

   logic [SYNC_STAGES-1:0] carry_sync, inc_sync, dec_sync;
   logic                   carry_hist, inc_hist, dec_hist;
   logic                   carry_ev, inc_ev, dec_ev;
   logic [7:0]             hour_cur, hour_nxt;
   logic                   day_nxt, alarm_nxt, alarm_valid;

   function automatic logic [7:0] bcd_inc(input logic [7:0] h);
      if (h == 8'h23)
         return 8'h00;
      else if (h[3:0] == 4'd9)
         return {h[7:4] + 4'd1, 4'd0};
      else
         return {h[7:4], h[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] h);
      if (h == 8'h00)
         return 8'h23;
      else if (h[3:0] == 4'd0)
         return {h[7:4] - 4'd1, 4'd9};
      else
         return {h[7:4], h[3:0] - 4'd1};
   endfunction

   // Synchronizers and history preset to 1 so a level held high across reset is not an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_sync <= '1;
         inc_sync   <= '1;
         dec_sync   <= '1;
         carry_hist <= 1'b1;
         inc_hist   <= 1'b1;
         dec_hist   <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every stage shift on the same edge.
         carry_sync <= {carry_sync[SYNC_STAGES-2:0], carry_in};
         inc_sync   <= {inc_sync[SYNC_STAGES-2:0], inc_btn};
         dec_sync   <= {dec_sync[SYNC_STAGES-2:0], dec_btn};
         carry_hist <= carry_sync[SYNC_STAGES-1];
         inc_hist   <= inc_sync[SYNC_STAGES-1];
         dec_hist   <= dec_sync[SYNC_STAGES-1];
      end
   end

   assign carry_ev = carry_sync[SYNC_STAGES-1] & ~carry_hist;
   assign inc_ev   = inc_sync[SYNC_STAGES-1] & ~inc_hist;
   assign dec_ev   = dec_sync[SYNC_STAGES-1] & ~dec_hist;
   assign hour_cur = {hour_high, hour_low};

   // Only a legal BCD hour can match; rejects e.g. 25 or 1A explicitly.
   assign alarm_valid = (alarm_high <= 4'd1 && alarm_low <= 4'd9) ||
                        (alarm_high == 4'd2 && alarm_low <= 4'd3);

   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      hour_nxt  = hour_cur;
      day_nxt   = 1'b0;
      alarm_nxt = 1'b0;
      if (!set_mode) begin
         if (carry_ev) begin
            hour_nxt  = bcd_inc(hour_cur);
            day_nxt   = (hour_cur == 8'h23);
            alarm_nxt = alarm_valid && (bcd_inc(hour_cur) == {alarm_high, alarm_low});
         end
      end else if (inc_ev && !dec_ev) begin
         hour_nxt = bcd_inc(hour_cur);
      end else if (dec_ev && !inc_ev) begin
         hour_nxt = bcd_dec(hour_cur);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: every flop here is reset; there is no memory array to leave uninitialized.
      if (rst) begin
         {hour_high, hour_low} <= RST_HOUR;
         day_pulse             <= 1'b0;
         alarm_hit             <= 1'b0;
      end else begin
         {hour_high, hour_low} <= hour_nxt;
         day_pulse             <= day_nxt;
         alarm_hit             <= alarm_nxt;
      end
   end

`ifdef H12_DISPLAY_EN
   // Returns {3'b0, tens, units, pm} of the 12-hour presentation of a BCD 24-hour value.
   function automatic logic [8:0] to_h12(input logic [7:0] h);
      logic [4:0] bin;
      logic [4:0] h12;
      logic       tens;
      bin = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
      if (bin == 5'd0)
         h12 = 5'd12;
      else if (bin > 5'd12)
         h12 = bin - 5'd12;
      else
         h12 = bin;
      tens = (h12 >= 5'd10);
      return {3'b000, tens, tens ? 4'(h12 - 5'd10) : 4'(h12), (bin >= 5'd12)};
   endfunction

   logic [8:0] h12_rst, h12_nxt;
   assign h12_rst = to_h12(RST_HOUR);
   assign h12_nxt = to_h12(hour_nxt);

   always_ff @(posedge clk) begin
      if (rst)
         {disp_high, disp_low, pm} <= h12_rst[5:0] == 6'd0 ? 9'd0 : h12_rst;
      else
         {disp_high, disp_low, pm} <= h12_nxt;
   end
`endif

endmodule

// File: tb/tb_h_gen_hour.sv
// Self-checking bench for h_gen_hour: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an integer-hour reference model.
module tb_h_gen_hour;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst, carry_in, set_mode, inc_btn, dec_btn;
   logic [3:0] alarm_high, alarm_low;
   logic [3:0] hour_high, hour_low;
   logic       day_pulse, alarm_hit;
`ifdef H12_DISPLAY_EN
   logic [3:0] disp_high, disp_low;
   logic       pm;
`endif

   h_gen_hour #(.SYNC_STAGES(S), .RST_HOUR_HIGH(0), .RST_HOUR_LOW(0)) dut (
      .clk(clk), .rst(rst), .carry_in(carry_in), .set_mode(set_mode),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .alarm_high(alarm_high), .alarm_low(alarm_low),
      .hour_high(hour_high), .hour_low(hour_low), .day_pulse(day_pulse), .alarm_hit(alarm_hit)
`ifdef H12_DISPLAY_EN
      , .disp_high(disp_high), .disp_low(disp_low), .pm(pm)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int day_cnt = 0, alarm_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int hr();
      return int'(hour_high) * 10 + int'(hour_low);
   endfunction

   // Reference model: hour as a plain integer, each input seen through a sample window.
   // An input rise counts when the sample S cycles back is 1 and the one before it is 0.
   int exp_hour = 0;
   bit exp_day = 0, exp_alarm = 0, model_ok = 0;
   bit wc[0:S], wi[0:S], wd[0:S];

   always @(posedge clk) begin : model
      bit ce, ie, de;
      int alarm_val;
      if (rst) begin
         exp_hour  = 0;
         exp_day   = 0;
         exp_alarm = 0;
         model_ok  = 1;
         for (int i = 0; i <= S; i++) begin
            wc[i] = 1; wi[i] = 1; wd[i] = 1;
         end
      end else if (model_ok) begin
         ce = wc[S-1] && !wc[S];
         ie = wi[S-1] && !wi[S];
         de = wd[S-1] && !wd[S];
         exp_day   = 0;
         exp_alarm = 0;
         if (!set_mode) begin
            if (ce) begin
               exp_day   = (exp_hour == 23);
               exp_hour  = (exp_hour + 1) % 24;
               alarm_val = int'(alarm_high) * 10 + int'(alarm_low);
               exp_alarm = (alarm_high <= 9) && (alarm_low <= 9) && (alarm_val == exp_hour);
            end
         end else if (ie && !de) begin
            exp_hour = (exp_hour + 1) % 24;
         end else if (de && !ie) begin
            exp_hour = (exp_hour + 23) % 24;
         end
         for (int i = S; i > 0; i--) begin
            wc[i] = wc[i-1]; wi[i] = wi[i-1]; wd[i] = wd[i-1];
         end
         wc[0] = carry_in; wi[0] = inc_btn; wd[0] = dec_btn;
      end
   end

   always @(negedge clk) begin : compare
      if (model_ok) begin
         check("hour", hr(), exp_hour);
         check("hour_low_bcd", int'(hour_low <= 4'd9), 1);
         check("day_pulse", day_pulse, exp_day);
         check("alarm_hit", alarm_hit, exp_alarm);
`ifdef H12_DISPLAY_EN
         check("disp", int'(disp_high) * 10 + int'(disp_low),
               exp_hour == 0 ? 12 : (exp_hour > 12 ? exp_hour - 12 : exp_hour));
         check("pm", pm, int'(exp_hour >= 12));
`endif
         if (day_pulse) day_cnt++;
         if (alarm_hit) alarm_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic carry_pulse();
      carry_in = 1; tick(2);
      carry_in = 0; tick(2);
   endtask

   task automatic btn_pulse(input bit inc, input bit dec);
      inc_btn = inc; dec_btn = dec; tick(2);
      inc_btn = 0;   dec_btn = 0;   tick(2);
   endtask

   task automatic set_hour(input int target);
      set_mode = 1;
      for (int g = 0; g < 24 && exp_hour != target; g++) btn_pulse(1, 0);
   endtask

   initial begin
      int d0, a0, a1;
      rst = 1; carry_in = 1; set_mode = 0; inc_btn = 0; dec_btn = 0;
      alarm_high = 4'd2; alarm_low = 4'd5;
      tick(3);
      rst = 0;

      // Carry held high through reset release must not count.
      tick(5);
      check("held_carry_no_advance", hr(), 0);
      check("held_carry_no_day", day_cnt, 0);
      carry_in = 0; tick(4);
      carry_in = 1;
      tick(1); check("carry_lat_k", hr(), 0);
      tick(1); check("carry_lat_k1", hr(), 0);
      tick(1); check("carry_lat_k2", hr(), 1);
      carry_in = 0; tick(2);

      // Full day of carries from 00.
      set_mode = 1; btn_pulse(0, 1); set_mode = 0;
      check("back_to_00", hr(), 0);
      d0 = day_cnt;
      for (int i = 1; i <= 24; i++) begin
         carry_pulse();
         check("carry_step", hr(), i % 24);
         check("day_count", day_cnt - d0, int'(i == 24));
      end

      // Set-mode wraps and discarded carry.
      set_mode = 1;
      d0 = day_cnt;
      btn_pulse(0, 1); check("set_dec_wrap", hr(), 23);
      btn_pulse(1, 0); check("set_inc_wrap", hr(), 0);
      check("set_wrap_no_day", day_cnt - d0, 0);
      carry_pulse();   check("carry_in_set_mode", hr(), 0);

      // Simultaneous inc and dec cancel.
      set_hour(9);
      btn_pulse(1, 1); check("inc_dec_cancel", hr(), 9);

      // Alarm.
      set_hour(6);
      set_mode = 0; alarm_high = 4'd0; alarm_low = 4'd7;
      a0 = alarm_cnt;
      carry_pulse();
      check("alarm_hour", hr(), 7);
      check("alarm_hit_once", alarm_cnt - a0, 1);
      set_mode = 1;
      btn_pulse(0, 1); btn_pulse(1, 0);
      check("set_inc_to_alarm", hr(), 7);
      check("set_no_alarm", alarm_cnt - a0, 1);
      set_mode = 0; alarm_high = 4'd2; alarm_low = 4'd5;
      a1 = alarm_cnt;
      repeat (24) carry_pulse();
      check("alarm25_full_day", hr(), 7);
      check("alarm25_never", alarm_cnt - a1, 0);

`ifdef H12_DISPLAY_EN
      begin
         int hs[5]  = '{0, 11, 12, 13, 23};
         int ds[5]  = '{12, 11, 12, 1, 11};
         int pms[5] = '{0, 0, 1, 1, 1};
         for (int i = 0; i < 5; i++) begin
            set_hour(hs[i]);
            check("h12_disp", int'(disp_high) * 10 + int'(disp_low), ds[i]);
            check("h12_pm", pm, pms[i]);
         end
         set_mode = 0;
      end
`endif

      // Reset while an edge sits in the synchronizer.
      set_mode = 0; set_hour(5); set_mode = 0;
      carry_in = 0; tick(2);
      carry_in = 1; tick(1);
      rst = 1; tick(1);
      rst = 0; tick(4);
      check("reset_drops_pending", hr(), 0);
      carry_in = 0; tick(2);

      // Randomized traffic; the compare process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         carry_in = 1'($urandom_range(0, 1));
         inc_btn  = ($urandom_range(0, 3) == 0);
         dec_btn  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) set_mode = ~set_mode;
         if ($urandom_range(0, 29) == 0) begin
            alarm_high = 4'($urandom_range(0, 3));
            alarm_low  = 4'($urandom_range(0, 11));
         end
         if ($urandom_range(0, 9) == 0) alarm_low = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 299) == 0);
         tick(1);
      end
      rst = 0; carry_in = 0; inc_btn = 0; dec_btn = 0;
      tick(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
